bfcpu_gen2: RTL and testbench

//  Second-generation Brainfuck core: fetches 8-bit opcodes over the i_ bus, caches one data cell, and executes ><+-.,[].

---
 rtl/bf_pkg.sv | 34 +++
 rtl/bf_loop_stack.sv | 64 ++++++
 rtl/bfcpu_gen2.sv | 277 +++++++++++++++++++++++++++
 tb/tb_bfcpu_gen2.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg -- shared definitions for the bfcpu_gen2 Brainfuck core.
//   * opcode byte values (OP_*), including the explicit halt opcode 0x00
//   * core FSM state encoding (state_t)
//   * bus direction constants (DIR_READ / DIR_WRITE)
// -----------------------------------------------------------------------------
package bf_pkg;

    localparam logic [7:0] OP_INC_DP = 8'h3E;  // '>'
    localparam logic [7:0] OP_DEC_DP = 8'h3C;  // '<'
    localparam logic [7:0] OP_INC    = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC    = 8'h2D;  // '-'
    localparam logic [7:0] OP_OUT    = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN     = 8'h2C;  // ','
    localparam logic [7:0] OP_LOOP   = 8'h5B;  // '['
    localparam logic [7:0] OP_END    = 8'h5D;  // ']'
    localparam logic [7:0] OP_HALT   = 8'h00;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_FETCH_W,
        ST_DECODE,
        ST_D_RD,
        ST_D_WR,
        ST_IO_RD,
        ST_IO_WR,
        ST_EXEC,
        ST_HALT
    } state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// -----------------------------------------------------------------------------
// bf_loop_stack -- return-address stack for '[' ... ']' loops.
//   STACK_DEPTH entries of I_ADDR_WIDTH bits.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears the pointer)
//   push, push_data store push_data on top (ignored when full)
//   pop             discard the top entry (ignored when empty)
//   top             current top entry (meaningless when empty)
//   full, empty     occupancy flags
// push and pop must not be asserted in the same cycle; the core never does so.
// -----------------------------------------------------------------------------
module bf_loop_stack
    import bf_pkg::*;
#(
    parameter int STACK_DEPTH  = 16,
    parameter int I_ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [I_ADDR_WIDTH-1:0] push_data,
    output logic [I_ADDR_WIDTH-1:0] top,
    output logic                    full,
    output logic                    empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    logic [I_ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [IDX_W-1:0]        wr_idx, top_idx;

    always_comb begin
        full    = (sp_q == SP_W'(STACK_DEPTH));
        empty   = (sp_q == '0);
        wr_idx  = IDX_W'(sp_q);
        top_idx = IDX_W'(sp_q - 1'b1);
        top     = mem_q[top_idx];
        sp_d    = sp_q;
        if (push && !full) begin
            sp_d = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entries are plain storage; only the pointer needs a reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/bfcpu_gen2.sv
// -----------------------------------------------------------------------------
// bfcpu_gen2 -- second-generation Brainfuck core.
// Fetches opcodes over the i_ bus, keeps one data cell cached (valid/dirty),
// and executes > < + - . , [ ] plus halt (0x00). Other bytes are NOPs.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_req/i_addr/i_ack/i_rdata   instruction fetch (i_addr = ip)
//   d_req/d_dir/d_addr/d_wdata/d_ack/d_rdata   cell memory (d_addr = dp)
//   io_req/io_dir/io_wdata/io_ack/io_rdata     byte I/O ('.' write, ',' read)
//   halt_n                       low once halted
//   err                          halted on loop-stack overflow/underflow
// Build option:
//   BFCPU_ICNT_EN  adds output icnt[31:0], count of retired opcodes
//                  (NOPs and skipped ones included), frozen in HALT.
// -----------------------------------------------------------------------------
module bfcpu_gen2
    import bf_pkg::*;
#(
    parameter int I_ADDR_WIDTH = 16,
    parameter int D_ADDR_WIDTH = 8,
    parameter int CELL_WIDTH   = 8,
    parameter int STACK_DEPTH  = 16,
    parameter int RESET_VECTOR = 0,
    parameter int RESET_DP     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    i_req,
    output logic [I_ADDR_WIDTH-1:0] i_addr,
    input  logic                    i_ack,
    input  logic [7:0]              i_rdata,
    output logic                    d_req,
    output logic                    d_dir,
    output logic [D_ADDR_WIDTH-1:0] d_addr,
    output logic [CELL_WIDTH-1:0]   d_wdata,
    input  logic                    d_ack,
    input  logic [CELL_WIDTH-1:0]   d_rdata,
    output logic                    io_req,
    output logic                    io_dir,
    output logic [7:0]              io_wdata,
    input  logic                    io_ack,
    input  logic [7:0]              io_rdata,
    output logic                    halt_n,
    output logic                    err
`ifdef BFCPU_ICNT_EN
    ,
    output logic [31:0]             icnt
`endif
);

    localparam int SKIP_W = $clog2(STACK_DEPTH) + 1;

    state_t                  state_q, state_d;
    logic [I_ADDR_WIDTH-1:0] ip_q, ip_d;
    logic [D_ADDR_WIDTH-1:0] dp_q, dp_d;
    logic [CELL_WIDTH-1:0]   cell_q, cell_d;
    logic                    cell_vld_q, cell_vld_d;
    logic                    cell_dirty_q, cell_dirty_d;
    logic [SKIP_W-1:0]       skip_q, skip_d;
    logic [7:0]              op_q, op_d;
    logic                    err_q, err_d;
    logic                    exec_now;
    logic                    uses_cell;
    logic                    stk_push, stk_pop;
    logic [I_ADDR_WIDTH-1:0] stk_top;
    logic                    stk_full, stk_empty;

    bf_loop_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .I_ADDR_WIDTH(I_ADDR_WIDTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(ip_q),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // State register (control) and cached data (no reset needed).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            ip_q         <= I_ADDR_WIDTH'(RESET_VECTOR);
            dp_q         <= D_ADDR_WIDTH'(RESET_DP);
            cell_vld_q   <= 1'b0;
            cell_dirty_q <= 1'b0;
            skip_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ip_q         <= ip_d;
            dp_q         <= dp_d;
            cell_vld_q   <= cell_vld_d;
            cell_dirty_q <= cell_dirty_d;
            skip_q       <= skip_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        cell_q <= cell_d;
        op_q   <= op_d;
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        ip_d         = ip_q;
        dp_d         = dp_q;
        cell_d       = cell_q;
        cell_vld_d   = cell_vld_q;
        cell_dirty_d = cell_dirty_q;
        skip_d       = skip_q;
        op_d         = op_q;
        err_d        = err_q;
        exec_now     = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        uses_cell    = (op_q == OP_INC) || (op_q == OP_DEC) || (op_q == OP_OUT) ||
                       (op_q == OP_LOOP) || (op_q == OP_END);

        unique case (state_q)
            ST_FETCH:   state_d = ST_FETCH_W;
            ST_FETCH_W: begin
                if (i_ack) begin
                    op_d    = i_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (skip_q != '0) begin
                    // Skipping a zero-cell loop: only bracket depth matters.
                    if (op_q == OP_LOOP && skip_q != '1) begin
                        skip_d = skip_q + 1'b1;
                    end else if (op_q == OP_END) begin
                        skip_d = skip_q - 1'b1;
                    end
                    ip_d    = ip_q + 1'b1;
                    state_d = ST_FETCH;
                end else if (op_q == OP_INC_DP || op_q == OP_DEC_DP || op_q == OP_HALT) begin
                    // Leaving the cell: write it back first if modified.
                    if (cell_dirty_q) state_d = ST_D_WR;
                    else              exec_now = 1'b1;
                end else if (op_q == OP_IN) begin
                    state_d = ST_IO_RD;
                end else if (uses_cell && !cell_vld_q) begin
                    state_d = ST_D_RD;
                end else begin
                    exec_now = 1'b1;
                end
            end
            ST_D_RD: begin
                if (d_ack) begin
                    cell_d       = d_rdata;
                    cell_vld_d   = 1'b1;
                    cell_dirty_d = 1'b0;
                    state_d      = ST_EXEC;
                end
            end
            ST_D_WR: begin
                if (d_ack) begin
                    cell_vld_d   = 1'b0;
                    cell_dirty_d = 1'b0;
                    state_d      = ST_EXEC;
                end
            end
            ST_IO_RD: begin
                if (io_ack) begin
                    cell_d       = CELL_WIDTH'(io_rdata);
                    cell_vld_d   = 1'b1;
                    cell_dirty_d = 1'b1;
                    ip_d         = ip_q + 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_IO_WR: begin
                if (io_ack) begin
                    ip_d    = ip_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: exec_now = 1'b1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // Execution with the cell cache already in the required condition.
        if (exec_now) begin
            state_d = ST_FETCH;
            ip_d    = ip_q + 1'b1;
            case (op_q)
                OP_HALT: begin
                    state_d = ST_HALT;
                    ip_d    = ip_q;
                end
                OP_INC: begin
                    cell_d       = cell_q + 1'b1;
                    cell_dirty_d = 1'b1;
                end
                OP_DEC: begin
                    cell_d       = cell_q - 1'b1;
                    cell_dirty_d = 1'b1;
                end
                OP_INC_DP, OP_DEC_DP: begin
                    dp_d         = (op_q == OP_INC_DP) ? dp_q + 1'b1 : dp_q - 1'b1;
                    cell_vld_d   = 1'b0;
                    cell_dirty_d = 1'b0;
                end
                OP_OUT: begin
                    state_d = ST_IO_WR;
                    ip_d    = ip_q;
                end
                OP_LOOP: begin
                    if (cell_q == '0) begin
                        skip_d = SKIP_W'(1);
                    end else if (stk_full) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                        ip_d    = ip_q;
                    end else begin
                        stk_push = 1'b1;
                    end
                end
                OP_END: begin
                    if (stk_empty) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                        ip_d    = ip_q;
                    end else if (cell_q != '0) begin
                        ip_d = stk_top + 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs: address/data are held at zero whenever the bus is idle.
    always_comb begin
        i_req    = (state_q == ST_FETCH_W);
        i_addr   = i_req ? ip_q : '0;
        d_req    = (state_q == ST_D_RD) || (state_q == ST_D_WR);
        d_dir    = (state_q == ST_D_WR) ? DIR_WRITE : DIR_READ;
        d_addr   = d_req ? dp_q : '0;
        d_wdata  = (state_q == ST_D_WR) ? cell_q : '0;
        io_req   = (state_q == ST_IO_RD) || (state_q == ST_IO_WR);
        io_dir   = (state_q == ST_IO_WR) ? DIR_WRITE : DIR_READ;
        io_wdata = (state_q == ST_IO_WR) ? cell_q[7:0] : 8'h00;
        halt_n   = (state_q != ST_HALT);
        err      = err_q;
    end

`ifdef BFCPU_ICNT_EN
    logic        retire;
    logic [31:0] icnt_q, icnt_d;

    // An opcode retires when an execution state hands back to FETCH or HALT.
    always_comb begin
        retire = ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                  (state_q == ST_IO_RD)  || (state_q == ST_IO_WR)) &&
                 ((state_d == ST_FETCH)  || (state_d == ST_HALT));
        icnt_d = icnt_q + (retire ? 32'd1 : 32'd0);
        icnt   = icnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) icnt_q <= '0;
        else     icnt_q <= icnt_d;
    end
`endif

endmodule

// File: tb/tb_bfcpu_gen2.sv
module tb_bfcpu_gen2;

    localparam int IAW   = 8;
    localparam int DAW   = 4;
    localparam int CW    = 12;
    localparam int SD    = 4;
    localparam int CMOD  = 1 << CW;
    localparam int NCELL = 1 << DAW;
    localparam int NINS  = 1 << IAW;
    localparam int SKMAX = (1 << ($clog2(SD) + 1)) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_req, i_ack = 1'b0;
    logic [IAW-1:0] i_addr;
    logic [7:0]     i_rdata = 8'h00;
    logic           d_req, d_dir, d_ack = 1'b0;
    logic [DAW-1:0] d_addr;
    logic [CW-1:0]  d_wdata, d_rdata = '0;
    logic           io_req, io_dir, io_ack = 1'b0;
    logic [7:0]     io_wdata, io_rdata = 8'h00;
    logic           halt_n, err;
`ifdef BFCPU_ICNT_EN
    logic [31:0]    icnt;
`endif

    always #5 clk = ~clk;

    bfcpu_gen2 #(
        .I_ADDR_WIDTH(IAW), .D_ADDR_WIDTH(DAW), .CELL_WIDTH(CW),
        .STACK_DEPTH(SD), .RESET_VECTOR(0), .RESET_DP(0)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .halt_n(halt_n), .err(err)
`ifdef BFCPU_ICNT_EN
        , .icnt(icnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Environment: instruction ROM, data RAM, I/O byte streams.
    logic [7:0]    imem [NINS];
    logic [CW-1:0] dmem [NCELL];
    logic [7:0]    in_q[$];
    logic [7:0]    out_q[$];
    int            d_wr_cnt = 0;
    int            i_cnt = -1, d_cnt = -1, io_cnt = -1;

    // Responders: random 0..5 cycle ack delay, driven on the falling edge.
    always @(negedge clk) begin
        if (!i_req) begin
            i_ack = 1'b0; i_cnt = -1;
        end else begin
            if (i_cnt < 0) i_cnt = $urandom_range(0, 5);
            if (i_cnt == 0) begin
                i_ack = 1'b1; i_rdata = imem[i_addr]; i_cnt = -1;
            end else begin
                i_ack = 1'b0; i_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (!d_req) begin
            d_ack = 1'b0; d_cnt = -1;
        end else begin
            if (d_cnt < 0) d_cnt = $urandom_range(0, 5);
            if (d_cnt == 0) begin
                d_ack = 1'b1; d_cnt = -1;
                if (d_dir) begin
                    dmem[d_addr] = d_wdata; d_wr_cnt++;
                end else begin
                    d_rdata = dmem[d_addr];
                end
            end else begin
                d_ack = 1'b0; d_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (!io_req) begin
            io_ack = 1'b0; io_cnt = -1;
        end else begin
            if (io_cnt < 0) io_cnt = $urandom_range(0, 5);
            if (io_cnt == 0) begin
                io_ack = 1'b1; io_cnt = -1;
                if (io_dir) out_q.push_back(io_wdata);
                else io_rdata = (in_q.size() > 0) ? in_q.pop_front() : 8'h00;
            end else begin
                io_ack = 1'b0; io_cnt--;
            end
        end
    end

    // Reference interpreter: plain Brainfuck on an integer tape. The RAM
    // image only changes when the cell is left or on a normal halt, and only
    // if the cell was modified since it was last loaded.
    int         m_mem [NCELL];
    int         m_out[$];
    logic [7:0] m_in[$];
    bit         m_err;
    int         m_retired, m_writes;

    task automatic model_run(output bit ok);
        int tape [NCELL];
        int stk[$];
        int ip, dp, skip, steps, in_idx;
        bit dirty;
        logic [7:0] op;
        ok = 0; m_err = 0; m_retired = 0; m_writes = 0; m_out.delete();
        for (int i = 0; i < NCELL; i++) begin
            m_mem[i] = int'(dmem[i]); tape[i] = int'(dmem[i]);
        end
        ip = 0; dp = 0; skip = 0; steps = 0; in_idx = 0; dirty = 0;
        while (steps < 200) begin
            op = imem[ip];
            steps++;
            m_retired++;
            if (skip > 0) begin
                if (op == "[") skip = (skip < SKMAX) ? skip + 1 : skip;
                else if (op == "]") skip--;
                ip = (ip + 1) % NINS;
                continue;
            end
            case (op)
                8'h00: begin
                    if (dirty) begin m_mem[dp] = tape[dp]; m_writes++; end
                    ok = 1; return;
                end
                "+": begin tape[dp] = (tape[dp] + 1) % CMOD; dirty = 1; end
                "-": begin tape[dp] = (tape[dp] + CMOD - 1) % CMOD; dirty = 1; end
                ">", "<": begin
                    if (dirty) begin m_mem[dp] = tape[dp]; m_writes++; end
                    dirty = 0;
                    dp = (op == ">") ? (dp + 1) % NCELL : (dp + NCELL - 1) % NCELL;
                end
                ".": m_out.push_back(tape[dp] % 256);
                ",": begin
                    tape[dp] = (in_idx < m_in.size()) ? int'(m_in[in_idx]) : 0;
                    in_idx++; dirty = 1;
                end
                "[": begin
                    if (tape[dp] == 0) skip = 1;
                    else if (stk.size() == SD) begin m_err = 1; ok = 1; return; end
                    else stk.push_back(ip);
                end
                "]": begin
                    if (stk.size() == 0) begin m_err = 1; ok = 1; return; end
                    if (tape[dp] != 0) begin ip = (stk[$] + 1) % NINS; continue; end
                    void'(stk.pop_back());
                end
                default: ;
            endcase
            ip = (ip + 1) % NINS;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_q.delete();
        d_wr_cnt = 0;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < NINS; i++) imem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) imem[i] = s[i];
    endtask

    task automatic prep_inputs();
        in_q.delete();
        for (int i = 0; i < 8; i++) in_q.push_back(8'($urandom_range(0, 255)));
        m_in = in_q;
    endtask

    // Runs the loaded program from reset; the model must already have run.
    task automatic run_dut(input string tag);
        int cyc;
        int reqs;
        do_reset();
        in_q = m_in;
        cyc = 0;
        while (!i_req && cyc < 50) begin @(negedge clk); cyc++; end
        chk({tag, ":first_fetch_addr"}, i_addr, 0);
        cyc = 0;
        while (halt_n && cyc < 20000) begin @(negedge clk); cyc++; end
        chk({tag, ":halted"}, halt_n, 0);
        chk({tag, ":err"}, err, m_err);
        chk({tag, ":out_count"}, out_q.size(), m_out.size());
        for (int i = 0; i < m_out.size() && i < out_q.size(); i++)
            chk($sformatf("%s:out[%0d]", tag, i), out_q[i], m_out[i]);
        chk({tag, ":d_writes"}, d_wr_cnt, m_writes);
        for (int i = 0; i < NCELL; i++)
            chk($sformatf("%s:dmem[%0d]", tag, i), dmem[i], m_mem[i]);
`ifdef BFCPU_ICNT_EN
        chk({tag, ":icnt"}, icnt, m_retired);
`endif
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (i_req || d_req || io_req) reqs++;
        end
        chk({tag, ":halt_absorbing"}, reqs, 0);
    endtask

    task automatic run_str(input string tag, input string s);
        bit ok;
        load_str(s);
        prep_inputs();
        model_run(ok);
        chk({tag, ":model_terminates"}, ok, 1);
        run_dut(tag);
    endtask

    initial begin
        string ops;
        bit ok;
        int cyc;
        ops = "++--<>>[].,,x";
        for (int i = 0; i < NCELL; i++) dmem[i] = '0;
        load_str("");
        do_reset();

        chk("rst:i_req", i_req, 0);
        chk("rst:d_req", d_req, 0);
        chk("rst:io_req", io_req, 0);
        chk("rst:i_addr", i_addr, 0);
        chk("rst:d_addr", d_addr, 0);
        chk("rst:d_wdata", d_wdata, 0);
        chk("rst:dirs", {d_dir, io_dir}, 0);
        chk("rst:halt_n", halt_n, 1);
        chk("rst:err", err, 0);

        run_str("inc3_out", "+++.");
        chk("inc3_out:value", (out_q.size() > 0) ? out_q[0] : 9'h1FF, 8'h03);
        chk("inc3_out:writeback", dmem[0], 3);

        for (int i = 0; i < NCELL; i++) dmem[i] = '0;
        run_str("dec_wrap", "-.");
        chk("dec_wrap:cell", dmem[0], CMOD - 1);

        for (int i = 0; i < NCELL; i++) dmem[i] = '0;
        run_str("move_loop", "++[>+<-]>.");
        for (int i = 0; i < NCELL; i++) dmem[i] = '0;
        run_str("skip_nest", "[+[+]+].");
        for (int i = 0; i < NCELL; i++) dmem[i] = '0;
        run_str("overflow", "+[[[[[");
        chk("overflow:err", err, 1);
        for (int i = 0; i < NCELL; i++) dmem[i] = '0;
        dmem[0] = 12'h001;
        run_str("underflow", "]");
        chk("underflow:err", err, 1);
        run_str("dp_wrap", "<+++<-->>.,.");

        // Reset pulsed while a data request is outstanding.
        load_str("+>+>+>+.");
        prep_inputs();
        do_reset();
        cyc = 0;
        while (!d_req && cyc < 300) begin @(negedge clk); cyc++; end
        chk("midrst:saw_d_req", d_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst:d_req_dropped", d_req, 0);
        chk("midrst:i_req_idle", i_req, 0);
        rst = 1'b0;
        model_run(ok);
        chk("midrst:model_terminates", ok, 1);
        run_dut("midrst_rerun");

        // Random programs; ones the model finds non-terminating are redrawn.
        for (int n = 0; n < 10; n++) begin
            ok = 0;
            while (!ok) begin
                for (int i = 0; i < NINS; i++) imem[i] = 8'h00;
                for (int i = 0; i < $urandom_range(6, 28); i++)
                    imem[i] = ops[$urandom_range(0, ops.len() - 1)];
                if ($urandom_range(0, 2) == 0)
                    for (int i = 0; i < NCELL; i++) dmem[i] = CW'($urandom_range(0, CMOD - 1));
                prep_inputs();
                model_run(ok);
            end
            run_dut($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
